conv_encoder_213: RTL
=====================

Name: conv_encoder_213

Overview:
- Rate-1/2, constraint-length-3 ((2,1,3)) convolutional encoder. It is the transmit-side counterpart of the efficient backward-label Viterbi decoder.
- Accepts a frame of information bits over a valid/ready handshake and emits one 2-bit code symbol per bit.
- Appends M=2 zero tail bits so the trellis terminates in state 00.
- Presents each symbol on Tx/seq_ready for SYM_HOLD clocks, so it can drive the decoder's Rx/seq_ready inputs directly in loopback benches and the system datapath.

Parameters:
- N, 2, code symbol width (bits per symbol)
- M, 2, encoder memory (tail length)
- G0, 3'b111, generator for Tx[1]; bit 2 taps the current input, bit 1 taps s[1], bit 0 taps s[0]
- G1, 3'b101, generator for Tx[0]; same tap ordering
- FRAME_LEN, 21, information bits per frame (21 + 2 tail = 23 symbols)
- SYM_HOLD, 3, clocks each symbol is held valid (legal range 1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle pulse that opens a frame; ignored unless state is IDLE
- din  in  1  information bit
- din_valid  in  1  din is valid
- din_ready  out  1  encoder accepts din this cycle
- Tx  out  N  code symbol, {c0,c1}
- seq_ready  out  1  Tx is valid (decoder handshake)
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse when the last tail symbol's hold ends

Behaviour:
- Reset (async, active-high): state=IDLE, s=2'b00, bit_cnt=0, hold_cnt=0, Tx=2'b00, seq_ready=0, din_ready=0, busy=0, frame_done=0.
- Reset asserted mid-frame aborts the frame immediately. No frame_done is generated.
- Encoder state s[1:0]: s[1] is the most recent bit. On each accepted bit d:
  - c0 = ^(G0 & {d,s})
  - c1 = ^(G1 & {d,s})
  - Tx <= {c0,c1}
  - s <= {d, s[1]}
- hold_cnt counts down from SYM_HOLD-1. seq_ready = (hold_cnt != 0) or (symbol loaded this cycle), so it is high for exactly SYM_HOLD clocks per symbol.
- Tx holds its value between symbols. When seq_ready=0, Tx is don't-care to the receiver.
- FSM states are IDLE, DATA, TAIL, DONE.
  - IDLE: start -> DATA, with bit_cnt=0 and s=00. A start pulse in any other state is ignored.
  - DATA:
    - din_ready = (hold_cnt==0) and the current hold has expired.
    - A bit is accepted on a clock edge where din_valid & din_ready. Tx and seq_ready are valid from the next cycle (latency 1).
    - Underrun: if din_valid=0 at an open slot, seq_ready drops and Tx holds. There is no timeout.
    - When the FRAME_LEN-th bit is accepted -> TAIL.
  - TAIL:
    - din_ready=0.
    - After the current hold expires, encode d=0 internally. Repeat M times, with the same pacing as DATA.
    - After the M-th tail symbol is loaded -> DONE.
  - DONE: wait for the final hold to expire, then pulse frame_done for one cycle and return to IDLE. s is guaranteed to be 00 at this point.
- Symbol pacing: back-to-back symbols are separated by exactly SYM_HOLD clocks, provided din_valid is high at each slot.
- Simultaneous events: start together with din_valid in IDLE starts the frame, but no bit is accepted that cycle.
- bit_cnt is wide enough for FRAME_LEN. It saturates, never wraps.
- Width rules: parity is computed by XOR reduction. N is fixed at 2. G0/G1 are M+1 bits.

Decomposition:
- Shared parameters include (alongside the decoder's):
  - N, M, G0, G1, SYM_HOLD
  - state encodings: IDLE=2'd0, DATA=2'd1, TAIL=2'd2, DONE=2'd3
- Sub-module enc_213_core: the s[1:0] shift register plus the parity network. It has a load-enable, a d input and {c0,c1} outputs.
- conv_encoder_213 holds the FSM, bit and hold counters, and the handshake.

Test Plan:
- Reset, then start and bits 1,0,1,1 with FRAME_LEN=4 and SYM_HOLD=3 -> Tx sequence 11,10,00,01 then tail symbols 01,11. Each symbol has seq_ready high for 3 clocks. frame_done pulses once after the 6th symbol, then busy=0.
- All-zero frame of 21 bits -> 23 symbols, all 00. Total frame length 23*3 clocks. frame_done pulses once.
- Underrun: din_valid low for 5 cycles after the 2nd bit -> seq_ready low during the gap, Tx unchanged. The sequence resumes correctly with no symbol lost.
- start pulsed during DATA and during TAIL -> ignored, bit_cnt unaffected. start together with din_valid in IDLE -> that bit is not accepted.
- Assert reset mid-TAIL -> all outputs return to reset values within the same cycle (async). The next frame encodes from s=00.
- Loopback into eVITERBI_213 using the 21-bit frame that produces the decoder's 23-symbol test vector set (no errors injected) -> decoded Dx equals the source bits and sync_error stays 0.

Source files
------------

// File: rtl/conv_encoder_213_pkg.sv
// Shared constants, state encoding and parity helper for the (2,1,3) encoder.
package conv_encoder_213_pkg;

  localparam int N = 2;
  localparam int M = 2;
  localparam logic [M:0] G0 = 3'b111;
  localparam logic [M:0] G1 = 3'b101;
  localparam int DEF_FRAME_LEN = 21;
  localparam int DEF_SYM_HOLD = 3;
  localparam int HOLD_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } enc_state_t;

  // Tap vector is ordered {current input, s[1], s[0]}.
  function automatic logic parity(input logic [M:0] g, input logic [M:0] v);
    return ^(g & v);
  endfunction

endpackage

// File: rtl/conv_encoder_213_core.sv
// Shift register plus parity network; code is combinational on the presented bit.
module enc_213_core
  import conv_encoder_213_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic         d,
  output logic [N-1:0] code
);

  logic [M-1:0] s;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s <= '0;
    end else if (clr) begin
      s <= '0;
    end else if (load) begin
      s <= {d, s[M-1:1]};
    end
  end

  always_comb begin
    code = {parity(G0, {d, s}), parity(G1, {d, s})};
  end

endmodule

// File: rtl/conv_encoder_213.sv
// Frame-level control: accepts FRAME_LEN bits, appends M zero tail bits, holds each symbol SYM_HOLD clocks.
module conv_encoder_213
  import conv_encoder_213_pkg::*;
#(
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int SYM_HOLD  = DEF_SYM_HOLD
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [N-1:0] Tx,
  output logic         seq_ready,
  output logic         busy,
  output logic         frame_done,
  output enc_state_t   dbg_state
);

  // Handshake: a bit transfers on a rising edge where din_valid && din_ready;
  // each transferred (or tail) symbol then shows seq_ready for SYM_HOLD clocks.
  localparam int BW = $clog2(FRAME_LEN + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_LEN - 1);
  localparam logic [BW-1:0] MAX_BIT = BW'(FRAME_LEN);
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(SYM_HOLD - 1);
  localparam logic [1:0] LAST_TAIL = 2'(M - 1);

  enc_state_t          state, state_nxt;
  logic [BW-1:0]       bit_cnt;
  logic [1:0]          tail_cnt;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                load, load_d, frame_start, done_nxt;
  logic [N-1:0]        code;

  enc_213_core u_core (
    .clock (clock),
    .reset (reset),
    .clr   (frame_start),
    .load  (load),
    .d     (load_d),
    .code  (code)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      tail_cnt   <= '0;
      hold_cnt   <= '0;
      Tx         <= '0;
      seq_ready  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      frame_done <= done_nxt;
      if (frame_start) begin
        bit_cnt  <= '0;
        tail_cnt <= '0;
      end
      if (load) begin
        Tx        <= code;
        hold_cnt  <= HOLD_INIT;
        seq_ready <= 1'b1;
        if (state == DATA && bit_cnt != MAX_BIT) bit_cnt <= bit_cnt + 1'b1;
        if (state == TAIL) tail_cnt <= tail_cnt + 1'b1;
      end else begin
        // Last hold cycle has hold_cnt==0; seq_ready falls after it unless a new symbol loads.
        seq_ready <= (hold_cnt != '0);
        if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    din_ready   = 1'b0;
    load        = 1'b0;
    load_d      = 1'b0;
    frame_start = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          frame_start = 1'b1;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        din_ready = (hold_cnt == '0);
        if (din_valid && din_ready) begin
          load   = 1'b1;
          load_d = din;
          if (bit_cnt == LAST_BIT) state_nxt = TAIL;
        end
      end
      TAIL: begin
        if (hold_cnt == '0) begin
          load = 1'b1;
          if (tail_cnt == LAST_TAIL) state_nxt = DONE;
        end
      end
      DONE: begin
        if (hold_cnt == '0) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
